gpu_cmd_issuer: RTL and testbench
=================================

Name: gpu_cmd_issuer

Overview:
Transmit end of the GPU command-stream interface (dv / din / ready).
Accepts packed high-level drawing requests from the CPU/MMIO side into a small queue.
Serialises each request into the exact word sequence the GPU command receiver consumes: a header word, then zero to four argument words on back-to-back cycles.
Sits between the MMIO register block and the GPU, in the single cpu clock domain.

Parameters:
FIFO_DEPTH, 4, request queue entries (power of 2, minimum 2)
WIDTH, 800, screen width in pixels
HEIGHT, 600, screen height in pixels
DEPTH, 2, bits per pixel (width of the colour index)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request offered
req_ready  out  1  queue can accept a request
req_op  in  2  0=Swap, 1=ChangeColorMap, 2=Pixel, 3=Rect
req_color  in  DEPTH  colour index for Pixel and Rect
req_x  in  10  Pixel/Rect x
req_y  in  10  Pixel/Rect y
req_w  in  10  Rect width
req_h  in  10  Rect height
req_cmap  in  96  four 24-bit RGB entries; entry0 = [23:0]
dv  out  1  word valid to GPU
dout  out  32  word to GPU
gpu_ready  in  1  GPU idle and able to take a header
busy  out  1  queue non-empty or FSM not in IDLE
cmds_issued  out  16  count of headers accepted by the GPU, wraps

Behaviour:
- Reset (async, rst=1): dv=0, dout=0, req_ready=0, busy=0, cmds_issued=0; queue flushed; FSM goes to IDLE. req_ready=1 from the first clock edge after rst falls.
- Reset mid-sequence: the partial command is abandoned immediately and no further words are driven.
- Queue: FIFO_DEPTH-entry FIFO of packed requests.
  - A push occurs on req_valid & req_ready.
  - req_ready = !full.
  - A push and a pop in the same cycle are legal when full; the count is unchanged.
- Word formats:
  - header = {14'b0, color[1:0], 14'b0, op[1:0]}; color is 0 for Swap and ChangeColorMap.
  - xy = {6'b0, y, 6'b0, x}
  - wh = {6'b0, h, 6'b0, w}
  - cmap word k = {8'b0, req_cmap[24k+23:24k]}
- FSM states: IDLE, HDR, A0, A1, A2, A3.
  - IDLE: when the queue is non-empty, pop the head into the working register and go to HDR on the next cycle. The minimum latency from push to header dv=1 is 2 cycles.
  - HDR: dv=1, dout=header. Hold until gpu_ready=1 at a rising edge; that edge is the handshake and increments cmds_issued. Then:
    - Swap → IDLE
    - Pixel → A0 (xy)
    - Rect → A0 (xy), A1 (wh)
    - ChangeColorMap → A0..A3 (cmap 0..3)
  - Argument states: dv=1, one word per cycle, strictly consecutive, ignoring gpu_ready (the GPU samples arguments unconditionally on the cycles following the header). After the last argument, dv=0 and the FSM returns to IDLE.
- dv is 0 in IDLE. dv stays high from the header through the last argument with no bubble.
- Back-to-back commands: the next header may be driven in the cycle after IDLE pops, but it is only accepted once gpu_ready returns. A Swap may hold gpu_ready low for up to a full frame; the issuer waits with no timeout.
- cmds_issued wraps from 16'hFFFF to 0.

Optional Feature:
GPU_CMD_CLIP_EN
- Defined:
  - Pixel with x>=WIDTH or y>=HEIGHT is dropped: popped, never transmitted, not counted.
  - Rect with x>=WIDTH, y>=HEIGHT, w==0 or h==0 is dropped the same way.
  - Otherwise w is clipped to min(w, WIDTH-x) and h to min(h, HEIGHT-y), using 11-bit intermediate arithmetic.
  - A dropped request costs one cycle in IDLE.
- Undefined: all fields are transmitted verbatim.

Decomposition:
- Shared package gpu_cmd_pkg holds:
  - op codes CMD_SWAP=0, CMD_CMAP=1, CMD_PIXEL=2, CMD_RECT=3
  - the argument count per op
  - header/xy/wh field positions
  - WIDTH/HEIGHT/DEPTH defaults
  - the packed request record type (2+DEPTH+40+96 bits)
  The GPU receiver imports the same package.
- One sub-module: gpu_cmd_fifo, a parametrised synchronous FIFO with async reset exposing full/empty/push/pop.

Test Plan:
1. Pixel op=2, color=3, x=5, y=7, gpu_ready=1 → dout 32'h0003_0002, then 32'h0007_0005 on the next cycle; dv high for exactly 2 cycles; cmds_issued=1.
2. Rect x=10, y=20, w=100, h=50, with gpu_ready held low 5 cycles → header held stable with dv=1 for 5 cycles; after ready rises, 32'h0014_000A then 32'h0032_0064 consecutively.
3. ChangeColorMap with cmap={FFFFFF,00FFFF,FF0000,000000} → header 32'h0000_0001, then 32'h0000_0000, 32'h00FF_0000, 32'h0000_FFFF, 32'h00FF_FFFF over 4 consecutive cycles.
4. Push 5 Swaps with gpu_ready=0 → req_ready=0 after 4 queued plus 1 in flight; releasing ready yields 5 header-only transfers and cmds_issued=5.
5. rst asserted during A1 of a Rect → dv=0 and dout=0 immediately (asynchronously), queue empty, cmds_issued=0.
6. With GPU_CMD_CLIP_EN: Rect x=790, y=595, w=20, h=20 → wh word 32'h0005_000A. Pixel x=800 → nothing transmitted, cmds_issued unchanged.

Source files
------------

// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg
//    Definitions shared by both ends of the GPU command-stream link (this
//    issuer and the GPU command receiver):
//    - op codes and the number of argument words each op carries
//    - header / xy / wh field positions and word builders
//    - default screen geometry
//    - the packed request record
//    - the issuer FSM state encoding
package gpu_cmd_pkg;

   localparam int GPU_WIDTH  = 800;
   localparam int GPU_HEIGHT = 600;
   localparam int GPU_DEPTH  = 2;

   // Field positions inside a 32-bit command word.
   localparam int HDR_OP_LSB    = 0;
   localparam int HDR_COLOR_LSB = 16;
   localparam int ARG_LO_LSB    = 0;   // x or w
   localparam int ARG_HI_LSB    = 16;  // y or h

   typedef enum logic [1:0] {
      CMD_SWAP  = 2'd0,
      CMD_CMAP  = 2'd1,
      CMD_PIXEL = 2'd2,
      CMD_RECT  = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_A0   = 3'd2,
      ST_A1   = 3'd3,
      ST_A2   = 3'd4,
      ST_A3   = 3'd5
   } issuer_state_e;

   // Packed request: 2 + GPU_DEPTH + 40 + 96 bits.
   typedef struct packed {
      cmd_op_e                op;
      logic [GPU_DEPTH-1:0]   color;
      logic [9:0]             x;
      logic [9:0]             y;
      logic [9:0]             w;
      logic [9:0]             h;
      logic [95:0]            cmap;
   } cmd_req_t;

   // Number of argument words that follow the header.
   function automatic logic [2:0] arg_count(input logic [1:0] op);
      logic [2:0] n;
      case (op)
         CMD_SWAP:  n = 3'd0;
         CMD_CMAP:  n = 3'd4;
         CMD_PIXEL: n = 3'd1;
         default:   n = 3'd2;
      endcase
      return n;
   endfunction

   // Swap and ChangeColorMap carry no colour; the field is forced to zero.
   function automatic logic [31:0] header_word(input logic [1:0] op,
                                               input logic [1:0] color);
      logic [31:0] wd;
      wd = '0;
      wd[HDR_OP_LSB +: 2] = op;
      if (op == CMD_PIXEL || op == CMD_RECT) begin
         wd[HDR_COLOR_LSB +: 2] = color;
      end
      return wd;
   endfunction

   // Shared layout for the xy and wh argument words.
   function automatic logic [31:0] arg_pair(input logic [9:0] lo,
                                            input logic [9:0] hi);
      logic [31:0] wd;
      wd = '0;
      wd[ARG_LO_LSB +: 10] = lo;
      wd[ARG_HI_LSB +: 10] = hi;
      return wd;
   endfunction

   function automatic logic [31:0] cmap_word(input logic [95:0] cmap,
                                             input logic [1:0]  k);
      logic [23:0] e;
      case (k)
         2'd0:    e = cmap[23:0];
         2'd1:    e = cmap[47:24];
         2'd2:    e = cmap[71:48];
         default: e = cmap[95:72];
      endcase
      return {8'h00, e};
   endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo
//    Synchronous FIFO with asynchronous active-high reset. The head entry is
//    presented combinationally on rdata_o while empty_o is low.
//    Ports:
//       clk, rst   clock, async reset (flushes pointers and count)
//       push_i     write wdata_i this cycle (ignored when full unless popping)
//       pop_i      drop the head entry this cycle (ignored when empty)
//       wdata_i    entry to write
//       rdata_o    head entry
//       full_o     DEPTH entries stored
//       empty_o    no entries stored
module gpu_cmd_fifo #(
   parameter int DEPTH = 4,   // power of 2, >= 2
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);

   // A push into a full FIFO is accepted only when the head leaves in the
   // same cycle; the slot being written is then the one being vacated.
   assign push_ok = push_i & (~full_o | pop_i);
   assign pop_ok  = pop_i & ~empty_o;

   assign rdata_o = mem_q[rptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/gpu_cmd_issuer.sv
// gpu_cmd_issuer
//    Transmit end of the GPU command-stream link. Queues drawing requests from
//    the MMIO side and serialises each one as a header word followed by 0..4
//    argument words on consecutive cycles.
//
//    Build option GPU_CMD_CLIP_EN: when defined, off-screen Pixel/Rect requests
//    are dropped and Rect width/height are clipped to the screen edge.
//
//    Ports:
//       clk, rst        clock, asynchronous active-high reset
//       req_valid/req_ready   request handshake (push on valid & ready)
//       req_op, req_color, req_x, req_y, req_w, req_h, req_cmap   request fields
//       dv, dout        word valid / word to GPU
//       gpu_ready       GPU can take a header
//       busy            queue non-empty or a command in flight
//       cmds_issued     headers accepted by the GPU (wrapping)
//       dbg_state_o     current FSM state (issuer_state_e encoding)
//
//    Handshakes:
//       Request side: a request is taken on a rising edge where req_valid and
//       req_ready are both high; req_ready does not depend on req_valid.
//       GPU side: the header is held with dv=1 until a rising edge with
//       gpu_ready=1; the argument words then follow one per cycle with dv=1
//       and do not wait on gpu_ready.
module gpu_cmd_issuer
   import gpu_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = GPU_WIDTH,
   parameter int HEIGHT     = GPU_HEIGHT,
   parameter int DEPTH      = GPU_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [DEPTH-1:0] req_color,
   input  logic [9:0]       req_x,
   input  logic [9:0]       req_y,
   input  logic [9:0]       req_w,
   input  logic [9:0]       req_h,
   input  logic [95:0]      req_cmap,
   output logic             dv,
   output logic [31:0]      dout,
   input  logic             gpu_ready,
   output logic             busy,
   output logic [15:0]      cmds_issued,
   output logic [2:0]       dbg_state_o
);

   localparam int REQ_W = $bits(cmd_req_t);

   issuer_state_e        state_q, state_d;
   cmd_req_t             push_rec, head_rec, head_fixed, work_q;
   logic [REQ_W-1:0]     head_raw;
   logic [GPU_DEPTH-1:0] color_w;
   logic                 fifo_full, fifo_empty;
   logic                 push, pop, head_drop, hdr_accept;
   logic                 rdy_en_q;
   logic [15:0]          issued_q;
   logic [2:0]           nargs;

   // ---------------------------------------------------------------- request queue
   if (DEPTH >= GPU_DEPTH) begin : g_col_trunc
      assign color_w = req_color[GPU_DEPTH-1:0];
   end else begin : g_col_ext
      assign color_w = {{(GPU_DEPTH-DEPTH){1'b0}}, req_color};
   end

   always_comb begin
      push_rec       = '0;
      push_rec.op    = cmd_op_e'(req_op);
      push_rec.color = color_w;
      push_rec.x     = req_x;
      push_rec.y     = req_y;
      push_rec.w     = req_w;
      push_rec.h     = req_h;
      push_rec.cmap  = req_cmap;
   end

   // rdy_en_q keeps req_ready low while reset is held and until the first
   // clock edge afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_en_q <= 1'b0;
      else     rdy_en_q <= 1'b1;
   end

   assign req_ready = rdy_en_q & ~fifo_full;
   assign push      = req_valid & req_ready;

   gpu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (REQ_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (push_rec),
      .rdata_o (head_raw),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_rec = cmd_req_t'(head_raw);

   // ---------------------------------------------------------------- clipping
`ifdef GPU_CMD_CLIP_EN
   logic [10:0] rem_w, rem_h;
   logic        x_out, y_out;

   always_comb begin
      head_fixed = head_rec;
      head_drop  = 1'b0;
      x_out      = ({1'b0, head_rec.x} >= 11'(WIDTH));
      y_out      = ({1'b0, head_rec.y} >= 11'(HEIGHT));
      // Space left to the screen edge; only meaningful when not out of range.
      rem_w      = 11'(WIDTH)  - {1'b0, head_rec.x};
      rem_h      = 11'(HEIGHT) - {1'b0, head_rec.y};
      if (head_rec.op == CMD_PIXEL) begin
         head_drop = x_out | y_out;
      end else if (head_rec.op == CMD_RECT) begin
         head_drop = x_out | y_out | (head_rec.w == 10'd0) | (head_rec.h == 10'd0);
         if ({1'b0, head_rec.w} > rem_w) head_fixed.w = rem_w[9:0];
         if ({1'b0, head_rec.h} > rem_h) head_fixed.h = rem_h[9:0];
      end
   end
`else
   always_comb begin
      head_fixed = head_rec;
      head_drop  = 1'b0;
   end
`endif

   // ---------------------------------------------------------------- FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   assign nargs = arg_count(work_q.op);

   // ---------------------------------------------------------------- FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!fifo_empty && !head_drop) state_d = ST_HDR;
         ST_HDR:  if (gpu_ready) state_d = (nargs == 3'd0) ? ST_IDLE : ST_A0;
         ST_A0:   state_d = (nargs > 3'd1) ? ST_A1 : ST_IDLE;
         ST_A1:   state_d = (nargs > 3'd2) ? ST_A2 : ST_IDLE;
         ST_A2:   state_d = ST_A3;
         ST_A3:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM: outputs
   // dv/dout decode from registered state only, so an async reset blanks the
   // link in the same instant.
   always_comb begin
      dv         = 1'b0;
      dout       = '0;
      pop        = 1'b0;
      hdr_accept = 1'b0;
      case (state_q)
         ST_IDLE: pop = ~fifo_empty;
         ST_HDR: begin
            dv         = 1'b1;
            dout       = header_word(work_q.op, work_q.color[1:0]);
            hdr_accept = gpu_ready;
         end
         ST_A0: begin
            dv   = 1'b1;
            dout = (work_q.op == CMD_CMAP) ? cmap_word(work_q.cmap, 2'd0)
                                           : arg_pair(work_q.x, work_q.y);
         end
         ST_A1: begin
            dv   = 1'b1;
            dout = (work_q.op == CMD_CMAP) ? cmap_word(work_q.cmap, 2'd1)
                                           : arg_pair(work_q.w, work_q.h);
         end
         ST_A2: begin
            dv   = 1'b1;
            dout = cmap_word(work_q.cmap, 2'd2);
         end
         ST_A3: begin
            dv   = 1'b1;
            dout = cmap_word(work_q.cmap, 2'd3);
         end
         default: begin
            dv   = 1'b0;
            dout = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------- working register / counter
   // A dropped head is popped without disturbing the working register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    work_q <= '0;
      else if (pop && !head_drop) work_q <= head_fixed;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             issued_q <= '0;
      else if (hdr_accept) issued_q <= issued_q + 16'd1;
   end

   assign cmds_issued = issued_q;
   assign busy        = ~fifo_empty | (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gpu_cmd_issuer.sv
// tb_gpu_cmd_issuer
//    Directed bench for gpu_cmd_issuer: a table of single-command vectors with
//    hand-computed word sequences, plus sequences for queue-full, clipping
//    (when built with GPU_CMD_CLIP_EN) and reset in the middle of a command.
module tb_gpu_cmd_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [1:0]  req_color;
   logic [9:0]  req_x, req_y, req_w, req_h;
   logic [95:0] req_cmap;
   logic        dv;
   logic [31:0] dout;
   logic        gpu_ready;
   logic        busy;
   logic [15:0] cmds_issued;
   logic [2:0]  dbg_state_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_issued = 0;
   string       cur_tag = "init";
   logic [31:0] exp_q[$];

   typedef struct packed {
      logic [1:0]       op;
      logic [1:0]       color;
      logic [9:0]       x;
      logic [9:0]       y;
      logic [9:0]       w;
      logic [9:0]       h;
      logic [95:0]      cmap;
      logic [3:0]       delay;   // cycles gpu_ready stays low under the header
      logic [2:0]       nwords;  // header + arguments
      logic [4:0][31:0] words;
   } vec_t;

   vec_t tbl [7];

   // ---------------------------------------------------------------- clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   gpu_cmd_issuer #(
      .FIFO_DEPTH (4),
      .WIDTH      (800),
      .HEIGHT     (600),
      .DEPTH      (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_color   (req_color),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_w       (req_w),
      .req_h       (req_h),
      .req_cmap    (req_cmap),
      .dv          (dv),
      .dout        (dout),
      .gpu_ready   (gpu_ready),
      .busy        (busy),
      .cmds_issued (cmds_issued),
      .dbg_state_o (dbg_state_o)
   );

   // ---------------------------------------------------------------- checking
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%s]: got %h, expected %h", name, cur_tag, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   // Called on a falling edge; the request is pushed on the following rising
   // edge and the task returns on the next falling edge.
   task automatic push_req(input logic [1:0] op, input logic [1:0] color,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] w, input logic [9:0] h,
                           input logic [95:0] cmap);
      chk("push_ready", {31'd0, req_ready}, 32'd1);
      req_op    = op;
      req_color = color;
      req_x     = x;
      req_y     = y;
      req_w     = w;
      req_h     = h;
      req_cmap  = cmap;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [1:0] color,
                               input logic [9:0] x, input logic [9:0] y,
                               input logic [9:0] w, input logic [9:0] h,
                               input logic [95:0] cmap, input int delay, input int nwords,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic [31:0] w4);
      vec_t v;
      v.op = op; v.color = color; v.x = x; v.y = y; v.w = w; v.h = h;
      v.cmap = cmap;
      v.delay = 4'(delay);
      v.nwords = 3'(nwords);
      v.words[0] = w0; v.words[1] = w1; v.words[2] = w2;
      v.words[3] = w3; v.words[4] = w4;
      return v;
   endfunction

   // Push one command into an idle DUT and follow its words on the link.
   task automatic run_vec(input vec_t v);
      int lat;
      gpu_ready = 1'b0;
      push_req(v.op, v.color, v.x, v.y, v.w, v.h, v.cmap);
      lat = 1;
      while (dv !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("hdr_latency", 32'(lat), 32'd2);
      if (dv !== 1'b1) return;
      for (int c = 0; c < int'(v.delay); c++) begin
         chk("hdr_hold_dv", {31'd0, dv}, 32'd1);
         chk("hdr_hold", dout, v.words[0]);
         @(negedge clk);
      end
      gpu_ready = 1'b1;
      chk("hdr_dv", {31'd0, dv}, 32'd1);
      chk("hdr", dout, v.words[0]);
      @(negedge clk);
      exp_issued++;
      for (int k = 1; k < int'(v.nwords); k++) begin
         chk("arg_dv", {31'd0, dv}, 32'd1);
         chk("arg", dout, v.words[k]);
         @(negedge clk);
      end
      chk("dv_end", {31'd0, dv}, 32'd0);
      chk("cmds_issued", {16'd0, cmds_issued}, 32'(exp_issued));
      gpu_ready = 1'b0;
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      logic bad_dv;
      logic [31:0] exp_w;

      tbl[0] = mk(2'd2, 2'd3, 10'd5, 10'd7, 10'd0, 10'd0, 96'd0, 0, 2,
                  32'h0003_0002, 32'h0007_0005, 32'h0, 32'h0, 32'h0);
      tbl[1] = mk(2'd3, 2'd1, 10'd10, 10'd20, 10'd100, 10'd50, 96'd0, 5, 3,
                  32'h0001_0003, 32'h0014_000A, 32'h0032_0064, 32'h0, 32'h0);
      tbl[2] = mk(2'd1, 2'd2, 10'd0, 10'd0, 10'd0, 10'd0,
                  {24'hFFFFFF, 24'h00FFFF, 24'hFF0000, 24'h000000}, 0, 5,
                  32'h0000_0001, 32'h0000_0000, 32'h00FF_0000, 32'h0000_FFFF, 32'h00FF_FFFF);
      tbl[3] = mk(2'd0, 2'd3, 10'd0, 10'd0, 10'd0, 10'd0, 96'd0, 2, 1,
                  32'h0000_0000, 32'h0, 32'h0, 32'h0, 32'h0);
      tbl[4] = mk(2'd2, 2'd1, 10'd799, 10'd599, 10'd0, 10'd0, 96'd0, 0, 2,
                  32'h0001_0002, 32'h0257_031F, 32'h0, 32'h0, 32'h0);
      tbl[5] = mk(2'd3, 2'd2, 10'd0, 10'd0, 10'd800, 10'd600, 96'd0, 1, 3,
                  32'h0002_0003, 32'h0000_0000, 32'h0258_0320, 32'h0, 32'h0);
      tbl[6] = mk(2'd1, 2'd0, 10'd0, 10'd0, 10'd0, 10'd0,
                  {24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'h808080}, 1, 5,
                  32'h0000_0001, 32'h0080_8080, 32'h000F_0F0F, 32'h00AB_CDEF, 32'h0012_3456);

      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_color = '0;
      req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_cmap = '0;
      gpu_ready = 1'b0;

      // Reset values
      cur_tag = "reset";
      repeat (3) @(negedge clk);
      chk("rst_dv", {31'd0, dv}, 32'd0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cmds", {16'd0, cmds_issued}, 32'd0);
      chk("rst_state", {29'd0, dbg_state_o}, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_before_edge", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("ready_after_edge", {31'd0, req_ready}, 32'd1);

      // Single-command table
      for (int i = 0; i < 7; i++) begin
         cur_tag = $sformatf("vec%0d", i);
         run_vec(tbl[i]);
      end

      // Five Swaps with the GPU busy: one in flight, four queued
      cur_tag = "swap_fill";
      gpu_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("fill_ready", {31'd0, req_ready}, 32'd1);
         req_op = 2'd0; req_color = 2'(i); req_valid = 1'b1;
         exp_q.push_back(32'h0000_0000);
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("full_ready", {31'd0, req_ready}, 32'd0);
      chk("full_busy", {31'd0, busy}, 32'd1);
      repeat (3) @(negedge clk);
      chk("full_ready_hold", {31'd0, req_ready}, 32'd0);
      chk("full_hdr_held", {31'd0, dv}, 32'd1);
      gpu_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (dv === 1'b1) begin
            chk("swap_extra", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_w = exp_q.pop_front();
               chk("swap_hdr", dout, exp_w);
               exp_issued++;
            end
         end
         @(negedge clk);
      end
      chk("swap_drained", 32'(exp_q.size()), 32'd0);
      chk("swap_cmds", {16'd0, cmds_issued}, 32'(exp_issued));
      chk("swap_busy", {31'd0, busy}, 32'd0);
      chk("swap_ready", {31'd0, req_ready}, 32'd1);
      gpu_ready = 1'b0;

`ifdef GPU_CMD_CLIP_EN
      // Clipped Rect, then dropped Pixel and zero-width Rect
      cur_tag = "clip_rect";
      run_vec(mk(2'd3, 2'd0, 10'd790, 10'd595, 10'd20, 10'd20, 96'd0, 0, 3,
                 32'h0000_0003, 32'h0253_0316, 32'h0005_000A, 32'h0, 32'h0));
      cur_tag = "clip_drop";
      gpu_ready = 1'b1;
      push_req(2'd2, 2'd1, 10'd800, 10'd0, 10'd0, 10'd0, 96'd0);
      push_req(2'd3, 2'd1, 10'd5, 10'd5, 10'd0, 10'd9, 96'd0);
      bad_dv = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (dv !== 1'b0) bad_dv = 1'b1;
         @(negedge clk);
      end
      chk("drop_no_dv", {31'd0, bad_dv}, 32'd0);
      chk("drop_cmds", {16'd0, cmds_issued}, 32'(exp_issued));
      chk("drop_busy", {31'd0, busy}, 32'd0);
      gpu_ready = 1'b0;
`endif

      // Reset during A1 of a Rect with a Pixel queued behind it
      cur_tag = "rst_mid";
      gpu_ready = 1'b1;
      push_req(2'd3, 2'd1, 10'd10, 10'd20, 10'd100, 10'd50, 96'd0);
      push_req(2'd2, 2'd2, 10'd1, 10'd2, 10'd0, 10'd0, 96'd0);
      chk("mid_hdr", dout, 32'h0001_0003);
      @(negedge clk);
      chk("mid_xy", dout, 32'h0014_000A);
      @(negedge clk);
      chk("mid_wh", dout, 32'h0032_0064);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      exp_issued = 0;
      chk("mid_rst_dv", {31'd0, dv}, 32'd0);
      chk("mid_rst_dout", dout, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_cmds", {16'd0, cmds_issued}, 32'd0);
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bad_dv = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (dv !== 1'b0) bad_dv = 1'b1;
      end
      chk("mid_no_words", {31'd0, bad_dv}, 32'd0);
      chk("mid_post_busy", {31'd0, busy}, 32'd0);
      chk("mid_post_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_post_cmds", {16'd0, cmds_issued}, 32'(exp_issued));

      // ---------------------------------------------------------------- report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
